// File: rtl/msx_mouse_pkg.sv
// Shared types, packet bit positions and the 8-bit clamp used when
// latching the movement accumulators for an MSX read sequence.
package msx_mouse_pkg;

  // Read-sequence phase. IDLE presents a zero nibble until the host strobes.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    XH   = 3'd1,
    XL   = 3'd2,
    YH   = 3'd3,
    YL   = 3'd4
  } phase_t;

  // Field positions inside the hps_io ps2_mouse word
  localparam int PS2_TOGGLE = 24;
  localparam int PS2_DY_MSB = 23;
  localparam int PS2_DY_LSB = 16;
  localparam int PS2_DX_MSB = 15;
  localparam int PS2_DX_LSB = 8;
  localparam int PS2_YSIGN  = 5;
  localparam int PS2_XSIGN  = 4;
  localparam int PS2_BTN_R  = 1;
  localparam int PS2_BTN_L  = 0;

  // Clamp a 10-bit signed accumulator into the signed byte the MSX reads
  function automatic logic [7:0] sat8(input logic signed [9:0] v);
    if (v > 10'sd127)
      return 8'h7F;
    else if (v < -10'sd128)
      return 8'h80;
    else
      return v[7:0];
  endfunction

endpackage

// File: rtl/mouse_delta_acc.sv
// One axis of movement accumulation. Saturates at -512/+511 and supports a
// clear that coincides with a new delta, in which case the result is 0+delta
// so the movement arriving on the latch cycle is carried into the next read.
module mouse_delta_acc (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic signed [9:0] delta,
  output logic signed [9:0] acc
);

  logic signed [9:0]  acc_reg;
  logic signed [9:0]  base;
  logic signed [10:0] sum;
  logic signed [9:0]  sum_sat;

  // The clear selects a zero base before the add, giving clear-with-load
  assign base = clear ? 10'sd0 : acc_reg;
  assign sum  = {base[9], base} + {delta[9], delta};

  // Clamp the 11-bit sum back into 10 bits instead of letting it wrap
  always_comb begin
    sum_sat = sum[9:0];
    if (sum > 11'sd511)
      sum_sat = 10'sd511;
    else if (sum < -11'sd512)
      sum_sat = -10'sd512;
  end

  // Accumulator register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      acc_reg <= '0;
    else if (load)
      acc_reg <= sum_sat;
    else if (clear)
      acc_reg <= '0;
  end

  assign acc = acc_reg;

endmodule

// File: rtl/msx_mouse_port.sv
// PS/2 mouse to MSX joystick-port mouse bridge. Packets from hps_io are
// accumulated per axis; the MSX strobe pin walks a four-nibble read
// sequence (X hi, X lo, Y hi, Y lo) and an idle strobe drops back to IDLE.
module msx_mouse_port
  import msx_mouse_pkg::*;
#(
  parameter int CLK_HZ      = 21477270,
  parameter int TIMEOUT_US  = 1500,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [24:0] ps2_mouse,
  input  logic        strobe,
  output logic [5:0]  data
);

  localparam longint TMO_L      = (longint'(TIMEOUT_US) * longint'(CLK_HZ)) / 64'sd1000000;
  localparam int     TMO_CYCLES = (TMO_L < 2) ? 2 : int'(TMO_L);
  localparam int     CNT_W      = $clog2(TMO_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYCLES - 1);

  // ---------------- packet intake ----------------
  logic              toggle_reg;
  logic [1:0]        btn_reg;     // [1] right, [0] left; 1 = pressed
  logic              packet;
  logic signed [9:0] dx10;
  logic signed [9:0] dy10;
  logic signed [9:0] neg_dx;
  logic signed [9:0] acc_x;
  logic signed [9:0] acc_y;
  logic              unused_bits;

  assign packet = ps2_mouse[PS2_TOGGLE] != toggle_reg;
  assign dx10   = {ps2_mouse[PS2_XSIGN], ps2_mouse[PS2_XSIGN], ps2_mouse[PS2_DX_MSB:PS2_DX_LSB]};
  assign dy10   = {ps2_mouse[PS2_YSIGN], ps2_mouse[PS2_YSIGN], ps2_mouse[PS2_DY_MSB:PS2_DY_LSB]};
  // MSX counts leftward motion as positive X, so X accumulates the negated delta
  assign neg_dx = -dx10;
  // Overflow flags and the always-one bit are not used by the MSX protocol
  assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:2]};

  // Track the packet toggle and sample the buttons on every packet
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      toggle_reg <= 1'b0;
      btn_reg    <= 2'b00;
    end else begin
      toggle_reg <= ps2_mouse[PS2_TOGGLE];
      if (packet)
        btn_reg <= {ps2_mouse[PS2_BTN_R], ps2_mouse[PS2_BTN_L]};
    end
  end

  // ---------------- strobe synchroniser and edge detect ----------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic [SYNC_STAGES:0]   arm_reg;
  logic                   edge_det;

  // Synchronise the pin and remember the previous synchronised level. The arm
  // shift register suppresses the false edge that would otherwise appear when
  // the pin is high while the reset-cleared chain refills after reset.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
      arm_reg  <= '0;
    end else begin
      sync_reg[0] <= strobe;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_reg[i] <= sync_reg[i-1];
      prev_reg <= sync_reg[SYNC_STAGES-1];
      arm_reg  <= {arm_reg[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign edge_det = arm_reg[SYNC_STAGES] && (sync_reg[SYNC_STAGES-1] != prev_reg);

  // ---------------- accumulators ----------------
  phase_t     phase_reg;
  logic       latch;
  logic [7:0] lat_x;
  logic [7:0] lat_y;

  assign latch = edge_det && ((phase_reg == IDLE) || (phase_reg == YL));
  assign lat_x = sat8(acc_x);
  assign lat_y = sat8(acc_y);

  mouse_delta_acc u_acc_x (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clear   (latch),
    .load    (packet),
    .delta   (neg_dx),
    .acc     (acc_x)
  );

  mouse_delta_acc u_acc_y (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clear   (latch),
    .load    (packet),
    .delta   (dy10),
    .acc     (acc_y)
  );

  // ---------------- phase FSM ----------------
  logic [7:0]       sat_x_reg;
  logic [7:0]       sat_y_reg;
  logic [3:0]       nibble_reg;
  logic [CNT_W-1:0] tmo_cnt_reg;

  // Advance on each strobe edge; fall back to IDLE after a quiet strobe.
  // An edge in the same cycle as expiry wins and restarts the count.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      phase_reg   <= IDLE;
      sat_x_reg   <= '0;
      sat_y_reg   <= '0;
      nibble_reg  <= '0;
      tmo_cnt_reg <= '0;
    end else if (edge_det) begin
      tmo_cnt_reg <= '0;
      unique case (phase_reg)
        IDLE, YL: begin
          phase_reg  <= XH;
          sat_x_reg  <= lat_x;
          sat_y_reg  <= lat_y;
          nibble_reg <= lat_x[7:4];
        end
        XH: begin
          phase_reg  <= XL;
          nibble_reg <= sat_x_reg[3:0];
        end
        XL: begin
          phase_reg  <= YH;
          nibble_reg <= sat_y_reg[7:4];
        end
        YH: begin
          phase_reg  <= YL;
          nibble_reg <= sat_y_reg[3:0];
        end
        default: begin
          phase_reg  <= IDLE;
          nibble_reg <= '0;
        end
      endcase
    end else if (phase_reg != IDLE) begin
      if (tmo_cnt_reg == TMO_LAST) begin
        phase_reg   <= IDLE;
        nibble_reg  <= '0;
        tmo_cnt_reg <= '0;
      end else begin
        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end
    end
  end

  // Buttons are active-low on the port and bypass the phase sequencing
  assign data = {~btn_reg[1], ~btn_reg[0], nibble_reg};

endmodule
